// File: rtl/byte_stream_packer.sv
// Packs PACK consecutive bytes into one little-endian word using valid/ready on both sides.
// Optional BYTE_STREAM_PACKER_WORD_COUNT_EN adds a free-running transferred-word counter.
module byte_stream_packer #(
    parameter int PACK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [8*PACK-1:0] m_data,
    output logic [PACK-1:0]   m_keep,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
`ifdef BYTE_STREAM_PACKER_WORD_COUNT_EN
    ,
    output logic [31:0]       word_count
`endif
);

    if (PACK < 2 || PACK > 8) begin : g_bad_pack
        $error("byte_stream_packer: PACK must be in 2..8");
    end

    localparam int IDX_W = $clog2(PACK);
    localparam int ACC_W = 8 * (PACK - 1);

    logic [ACC_W-1:0]  acc;
    logic [PACK-2:0]   mask;
    logic [IDX_W-1:0]  idx;

    logic              accept;
    logic              complete;
    logic              drain;
    logic [8*PACK-1:0] merged;
    logic [PACK-1:0]   keep_next;

    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign complete = accept && (s_last || (idx == IDX_W'(PACK - 1)));
    assign drain    = m_valid && m_ready;

    // Lanes above idx are always zero in the accumulator, so OR-merging keeps unused lanes 0.
    assign merged    = {8'h00, acc} | ({{ACC_W{1'b0}}, s_data} << {idx, 3'b000});
    assign keep_next = {1'b0, mask} | ({{(PACK-1){1'b0}}, 1'b1} << idx);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mask    <= '0;
            idx     <= '0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (complete) begin
            m_data  <= merged;
            m_keep  <= keep_next;
            m_last  <= s_last;
            m_valid <= 1'b1;
            acc     <= '0;
            mask    <= '0;
            idx     <= '0;
        end else begin
            if (drain) begin
                m_valid <= 1'b0;
            end
            if (accept) begin
                // Not completing implies idx < PACK-1, so the new byte lies inside acc.
                acc  <= merged[ACC_W-1:0];
                mask <= keep_next[PACK-2:0];
                idx  <= idx + IDX_W'(1);
            end
        end
    end

`ifdef BYTE_STREAM_PACKER_WORD_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (drain) begin
            word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/byte_stream_packer.md
Name: byte_stream_packer

Overview:
- Consumes the 8-bit data stream produced by the byte-wide source stage and packs PACK consecutive bytes into one wide output word, using valid/ready handshakes on both sides.
- Little-endian lane order: the first byte accepted lands in bits [7:0].
- A short final word is allowed. It is flushed by s_last and flagged by m_keep/m_last.
- Sits directly downstream of the byte source and feeds the wide datapath.

Parameters:
- PACK, 4, bytes per output word. Legal range 2..8; any other value is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- s_data  input  8  input byte
- s_valid  input  1  s_data valid
- s_ready  output  1  packer can accept a byte this cycle
- s_last  input  1  current byte closes the word (packet end)
- m_data  output  8*PACK  packed word
- m_keep  output  PACK  lane-valid mask; bit i covers m_data[8i+7:8i]
- m_last  output  1  word ends a packet
- m_valid  output  1  m_data/m_keep/m_last valid
- m_ready  input  1  downstream accepts word

Behaviour:
- Clock and reset: single clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - m_valid=0, m_data=0, m_keep=0, m_last=0.
  - Internal accumulator, lane mask and lane index idx all cleared to 0.
  - s_ready=1 while out of reset, since it is combinational from m_valid=0.
- Storage: accumulator (PACK-1 bytes, lane mask, idx 0..PACK-1) plus one output register (m_*).
- Handshake rules:
  - Byte accepted when s_valid && s_ready.
  - Word transferred when m_valid && m_ready.
- s_ready = !m_valid || m_ready, combinational from m_ready; no other path from m_ready to outputs.
- Accepted byte, not completing (idx<PACK-1 and s_last=0):
  - Byte is written to accumulator lane idx, its mask bit is set, and idx increments.
  - Output register is untouched.
- Accepted byte, completing (idx==PACK-1 or s_last=1):
  - Output register loads the accumulator merged with the new byte at lane idx.
  - m_keep = mask with bit idx set; m_last = s_last; m_valid=1 from the next cycle.
  - Accumulator, mask and idx clear in the same cycle.
- Latency: word visible on m_* exactly 1 cycle after its completing byte is accepted.
- Unused lanes of a short word read 0. m_keep is always contiguous from bit 0.
- Word transferred with no new completing byte: m_valid clears next cycle; m_data/m_keep/m_last hold their last values.
- Simultaneous drain + completing byte: the new word replaces the old one and m_valid stays 1. Sustained rate is 1 byte/cycle.
- Stall (m_valid && !m_ready): s_ready=0, and m_data/m_keep/m_last are held stable until accepted.
- s_last with idx==PACK-1: a full word with m_last=1, m_keep all ones.
- s_valid=0 mid-word: accumulator holds indefinitely; there is no timeout flush.
- rst asserted mid-word or mid-stall: a partial word is discarded and a pending output word is dropped; all state returns to reset values immediately.

Optional Feature:
- Macro: BYTE_STREAM_PACKER_WORD_COUNT_EN.
- Defined:
  - Adds output port word_count [31:0], reset 0.
  - Increments by 1 on each m_valid && m_ready and wraps from 32'hFFFFFFFF to 0.
  - Registered output, so it reflects a transfer the cycle after it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
All scenarios use PACK=4.
1. Bytes AB,CD,EF,01 consecutive, m_ready=1 -> one cycle after 4th accept: m_valid=1, m_data=32'h01EFCDAB, m_keep=4'hF, m_last=0.
2. Single byte AB with s_last=1 -> m_data=32'h000000AB, m_keep=4'h1, m_last=1; then 2 bytes 11,22 with s_last on 22 -> m_data=32'h00002211, m_keep=4'h3, m_last=1.
3. Bytes 00..07 streamed continuously, m_ready=1 -> words 32'h03020100 then 32'h07060504 on consecutive-word boundaries; s_ready never drops.
4. Complete word 32'h44332211, m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0 all 5 cycles, m_data stable; m_ready=1 -> transfer, s_ready=1 same cycle, next byte accepted into lane 0.
5. Accept 55,66, pulse rst mid-cycle (asynchronous), then send 01,02,03,04 -> m_valid=0 immediately on rst; next word 32'h04030201, m_keep=4'hF, no 55/66 present.
6. With BYTE_STREAM_PACKER_WORD_COUNT_EN, preload count 32'hFFFFFFFE via two forced transfers from a bench-initialised state; transfer 3 words -> word_count goes FFFFFFFF, 0, 1; reset -> 0.
